// File: rtl/tl_ram_responder_if.sv
// TileLink-UL style A/D channel bundle for the RAM responder.
// master drives requests and consumes responses; slave is the responder.
interface tl_ram_responder_if;
   logic         auto_in_a_valid;
   logic         auto_in_a_ready;
   logic [2:0]   auto_in_a_bits_opcode;
   logic [2:0]   auto_in_a_bits_param;
   logic [2:0]   auto_in_a_bits_size;
   logic [5:0]   auto_in_a_bits_source;
   logic [31:0]  auto_in_a_bits_address;
   logic [15:0]  auto_in_a_bits_mask;
   logic [127:0] auto_in_a_bits_data;
   logic         auto_in_a_bits_corrupt;

   logic         auto_in_d_ready;
   logic         auto_in_d_valid;
   logic [2:0]   auto_in_d_bits_opcode;
   logic [1:0]   auto_in_d_bits_param;
   logic [2:0]   auto_in_d_bits_size;
   logic [5:0]   auto_in_d_bits_source;
   logic [3:0]   auto_in_d_bits_sink;
   logic         auto_in_d_bits_denied;
   logic [127:0] auto_in_d_bits_data;
   logic         auto_in_d_bits_corrupt;

   modport master (
      output auto_in_a_valid,
      input  auto_in_a_ready,
      output auto_in_a_bits_opcode,
      output auto_in_a_bits_param,
      output auto_in_a_bits_size,
      output auto_in_a_bits_source,
      output auto_in_a_bits_address,
      output auto_in_a_bits_mask,
      output auto_in_a_bits_data,
      output auto_in_a_bits_corrupt,
      output auto_in_d_ready,
      input  auto_in_d_valid,
      input  auto_in_d_bits_opcode,
      input  auto_in_d_bits_param,
      input  auto_in_d_bits_size,
      input  auto_in_d_bits_source,
      input  auto_in_d_bits_sink,
      input  auto_in_d_bits_denied,
      input  auto_in_d_bits_data,
      input  auto_in_d_bits_corrupt
   );

   modport slave (
      input  auto_in_a_valid,
      output auto_in_a_ready,
      input  auto_in_a_bits_opcode,
      input  auto_in_a_bits_param,
      input  auto_in_a_bits_size,
      input  auto_in_a_bits_source,
      input  auto_in_a_bits_address,
      input  auto_in_a_bits_mask,
      input  auto_in_a_bits_data,
      input  auto_in_a_bits_corrupt,
      input  auto_in_d_ready,
      output auto_in_d_valid,
      output auto_in_d_bits_opcode,
      output auto_in_d_bits_param,
      output auto_in_d_bits_size,
      output auto_in_d_bits_source,
      output auto_in_d_bits_sink,
      output auto_in_d_bits_denied,
      output auto_in_d_bits_data,
      output auto_in_d_bits_corrupt
   );
endinterface

// File: rtl/tl_ram_responder.sv
// 4 KiB 128-bit-wide RAM behind a TileLink A/D port.
// Serves Get, PutFullData and PutPartialData bursts of up to 4 beats.
module tl_ram_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input logic clock,
   input logic reset,
   tl_ram_responder_if.slave tl
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PUT  = 2'd1;
   localparam logic [1:0] GET  = 2'd2;
   localparam logic [1:0] ACK  = 2'd3;

   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_GET      = 3'd4;

   // Index of the final beat of a burst of 2^size bytes.
   function automatic logic [2:0] last_beat(input logic [2:0] size);
      logic [2:0] r;
      case (size)
         3'd5:    r = 3'd1;
         3'd6:    r = 3'd3;
         3'd7:    r = 3'd7;
         default: r = 3'd0;
      endcase
      return r;
   endfunction

   logic [1:0]   state;
   logic [2:0]   beat;
   logic [2:0]   opcode_q;
   logic [2:0]   size_q;
   logic [5:0]   source_q;
   logic [7:0]   base_q;
   logic         denied_q;
   logic [127:0] ram [0:255];

   logic         a_fire;
   logic         d_fire;
   logic         a_ready;
   logic         d_valid;
   logic [2:0]   a_op;
   logic [2:0]   a_size;
   logic         a_is_get;
   logic         a_is_put;
   logic [31:0]  a_offset;
   logic         a_in_window;
   logic         a_denied;
   logic         q_is_put;
   logic         wr_en;
   logic [7:0]   wr_idx;
   logic [7:0]   rd_idx;
   logic         unused_bits;

   assign a_op     = tl.auto_in_a_bits_opcode;
   assign a_size   = tl.auto_in_a_bits_size;
   assign a_is_get = (a_op == OP_GET);
   assign a_is_put = (a_op == OP_PUT_FULL) ||
                     (a_op == OP_PUT_PART);

   // Modular offset keeps the window test correct near 2^32.
   assign a_offset    = tl.auto_in_a_bits_address - BASE_ADDR;
   assign a_in_window = (a_offset[31:12] == 20'd0);
   assign a_denied    = !(a_is_get || a_is_put) ||
                        (a_size == 3'd7) ||
                        !a_in_window;

   assign a_ready = (state == IDLE) || (state == PUT);
   assign d_valid = (state == GET) || (state == ACK);
   assign a_fire  = tl.auto_in_a_valid & a_ready;
   assign d_fire  = d_valid & tl.auto_in_d_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         beat     <= 3'd0;
         opcode_q <= 3'd0;
         size_q   <= 3'd0;
         source_q <= 6'd0;
         base_q   <= 8'd0;
         denied_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (a_fire) begin
                  opcode_q <= a_op;
                  size_q   <= a_size;
                  source_q <= tl.auto_in_a_bits_source;
                  base_q   <= tl.auto_in_a_bits_address[11:4];
                  denied_q <= a_denied;
                  if (a_is_get) begin
                     state <= GET;
                     beat  <= 3'd0;
                  end else if (last_beat(a_size) == 3'd0) begin
                     state <= ACK;
                     beat  <= 3'd0;
                  end else begin
                     state <= PUT;
                     beat  <= 3'd1;
                  end
               end
            end
            PUT: begin
               if (a_fire) begin
                  if (beat == last_beat(size_q)) begin
                     state <= ACK;
                     beat  <= 3'd0;
                  end else begin
                     beat <= beat + 3'd1;
                  end
               end
            end
            GET: begin
               if (d_fire) begin
                  if (beat == last_beat(size_q)) begin
                     state <= IDLE;
                     beat  <= 3'd0;
                  end else begin
                     beat <= beat + 3'd1;
                  end
               end
            end
            ACK: begin
               if (d_fire) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // First beat decides from the live request, later beats from the latch.
   assign q_is_put = (opcode_q == OP_PUT_FULL) ||
                     (opcode_q == OP_PUT_PART);

   always_comb begin
      wr_en  = 1'b0;
      wr_idx = base_q + {5'd0, beat};
      if (state == IDLE) begin
         wr_idx = tl.auto_in_a_bits_address[11:4];
         wr_en  = a_is_put && !a_denied;
      end else if (state == PUT) begin
         wr_en = q_is_put && !denied_q;
      end
      wr_en = wr_en && a_fire && reset;
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < 16; b++) begin
            if (tl.auto_in_a_bits_mask[b]) begin
               ram[wr_idx][b*8 +: 8] <=
                  tl.auto_in_a_bits_data[b*8 +: 8];
            end
         end
      end
   end

   assign rd_idx = base_q + {5'd0, beat};

   assign tl.auto_in_a_ready = a_ready;
   assign tl.auto_in_d_valid = d_valid;

   assign tl.auto_in_d_bits_opcode =
      (state == GET) ? 3'd1 : 3'd0;
   assign tl.auto_in_d_bits_param  = 2'd0;
   assign tl.auto_in_d_bits_sink   = 4'd0;
   assign tl.auto_in_d_bits_size   = d_valid ? size_q : 3'd0;
   assign tl.auto_in_d_bits_source = d_valid ? source_q : 6'd0;
   assign tl.auto_in_d_bits_denied = d_valid & denied_q;
   assign tl.auto_in_d_bits_corrupt =
      (state == GET) & denied_q;
   assign tl.auto_in_d_bits_data =
      ((state == GET) && !denied_q) ? ram[rd_idx] : 128'd0;

   assign unused_bits = ^{tl.auto_in_a_bits_param,
                          tl.auto_in_a_bits_corrupt,
                          a_offset[11:0]};

endmodule

// File: tb/tb_tl_ram_responder.sv
// Randomized bench for tl_ram_responder against a flat memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tl_ram_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [127:0] mem [256];
   logic [127:0] wd  [8];
   logic [15:0]  wm  [8];

   tl_ram_responder_if bus ();

   tl_ram_responder #(.BASE_ADDR(BASE)) dut (
      .clock (clock),
      .reset (reset),
      .tl    (bus)
   );

   always #5 clock = ~clock;

   function automatic int n_beats(input logic [2:0] size);
      int s;
      s = int'(size);
      return (s <= 4) ? 1 : (1 << (s - 4));
   endfunction

   function automatic bit is_denied(input logic [2:0] op,
                                    input logic [31:0] addr,
                                    input logic [2:0] size);
      longint unsigned a;
      longint unsigned lo;
      a  = longint'(addr);
      lo = longint'(BASE);
      return !(op == 3'd0 || op == 3'd1 || op == 3'd4) ||
             (int'(size) > 6) || (a < lo) || (a >= lo + 4096);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [148:0] got_d();
      return {bus.auto_in_d_valid, bus.auto_in_d_bits_opcode,
              bus.auto_in_d_bits_param, bus.auto_in_d_bits_size,
              bus.auto_in_d_bits_source, bus.auto_in_d_bits_sink,
              bus.auto_in_d_bits_denied, bus.auto_in_d_bits_corrupt,
              bus.auto_in_d_bits_data};
   endfunction

   task automatic idle_a();
      bus.auto_in_a_valid        = 1'b0;
      bus.auto_in_a_bits_opcode  = 3'($urandom);
      bus.auto_in_a_bits_param   = 3'($urandom);
      bus.auto_in_a_bits_size    = 3'($urandom);
      bus.auto_in_a_bits_source  = 6'($urandom);
      bus.auto_in_a_bits_address = $urandom;
      bus.auto_in_a_bits_mask    = 16'($urandom);
      bus.auto_in_a_bits_data    = rnd128();
      bus.auto_in_a_bits_corrupt = 1'($urandom);
   endtask

   task automatic put_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [2:0] size, input logic [5:0] src,
                          input int stall, input string tag);
      int          n;
      bit          den;
      logic [7:0]  idx;
      logic [7:0]  i8;
      logic [148:0] exp;
      n   = n_beats(size);
      den = is_denied(op, addr, size);
      idx = addr[11:4];
      for (int k = 0; k < n; k++) begin
         idle_a();
         bus.auto_in_a_valid     = 1'b1;
         bus.auto_in_a_bits_mask = wm[k];
         bus.auto_in_a_bits_data = wd[k];
         if (k == 0) begin
            bus.auto_in_a_bits_opcode  = op;
            bus.auto_in_a_bits_size    = size;
            bus.auto_in_a_bits_source  = src;
            bus.auto_in_a_bits_address = addr;
         end
         checks++;
         if (bus.auto_in_a_ready !== 1'b1 || bus.auto_in_d_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s a beat %0d: got ready=%b dvalid=%b, want ready=1 dvalid=0",
                     tag, k, bus.auto_in_a_ready, bus.auto_in_d_valid);
         end
         @(posedge clock);
         if (!den) begin
            i8 = idx + 8'(k);
            for (int b = 0; b < 16; b++)
               if (wm[k][b]) mem[i8][b*8 +: 8] = wd[k][b*8 +: 8];
         end
         @(negedge clock);
      end
      idle_a();
      exp = {1'b1, 3'd0, 2'd0, size, src, 4'd0, den, 1'b0, 128'd0};
      for (int c = 0; c <= stall; c++) begin
         checks++;
         if (got_d() !== exp || bus.auto_in_a_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ack cyc %0d: got %h ready=%b, want %h ready=0",
                     tag, c, got_d(), bus.auto_in_a_ready, exp);
         end
         bus.auto_in_d_ready = (c == stall);
         @(negedge clock);
      end
      bus.auto_in_d_ready = 1'b0;
      checks++;
      if (bus.auto_in_d_valid !== 1'b0 || bus.auto_in_a_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s end: got dvalid=%b ready=%b, want dvalid=0 ready=1",
                  tag, bus.auto_in_d_valid, bus.auto_in_a_ready);
      end
   endtask

   task automatic get_req(input logic [31:0] addr, input logic [2:0] size,
                          input logic [5:0] src, input int max_stall,
                          input string tag);
      int           n;
      int           st;
      bit           den;
      logic [7:0]   idx;
      logic [127:0] dat;
      logic [148:0] exp;
      n   = n_beats(size);
      den = is_denied(3'd4, addr, size);
      idx = addr[11:4];
      idle_a();
      bus.auto_in_a_valid        = 1'b1;
      bus.auto_in_a_bits_opcode  = 3'd4;
      bus.auto_in_a_bits_size    = size;
      bus.auto_in_a_bits_source  = src;
      bus.auto_in_a_bits_address = addr;
      checks++;
      if (bus.auto_in_a_ready !== 1'b1 || bus.auto_in_d_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s a: got ready=%b dvalid=%b, want ready=1 dvalid=0",
                  tag, bus.auto_in_a_ready, bus.auto_in_d_valid);
      end
      @(posedge clock);
      @(negedge clock);
      idle_a();
      for (int k = 0; k < n; k++) begin
         dat = den ? 128'd0 : mem[idx + 8'(k)];
         exp = {1'b1, 3'd1, 2'd0, size, src, 4'd0, den, den, dat};
         st  = int'($urandom_range(0, max_stall));
         for (int c = 0; c <= st; c++) begin
            checks++;
            if (got_d() !== exp || bus.auto_in_a_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s beat %0d cyc %0d: got %h ready=%b, want %h ready=0",
                        tag, k, c, got_d(), bus.auto_in_a_ready, exp);
            end
            bus.auto_in_d_ready = (c == st);
            @(negedge clock);
         end
         bus.auto_in_d_ready = 1'b0;
      end
      checks++;
      if (bus.auto_in_d_valid !== 1'b0 || bus.auto_in_a_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s end: got dvalid=%b ready=%b, want dvalid=0 ready=1",
                  tag, bus.auto_in_d_valid, bus.auto_in_a_ready);
      end
   endtask

   task automatic test_reset();
      logic [148:0] zero;
      zero = '0;
      idle_a();
      bus.auto_in_d_ready = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (got_d() !== zero || bus.auto_in_a_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_hold: got %h ready=%b, want %h ready=1",
                  got_d(), bus.auto_in_a_ready, zero);
      end
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (got_d() !== zero || bus.auto_in_a_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got %h ready=%b, want %h ready=1",
                  got_d(), bus.auto_in_a_ready, zero);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 64; i++) begin
         for (int k = 0; k < 4; k++) begin
            wd[k] = rnd128();
            wm[k] = 16'hFFFF;
         end
         put_req(3'($urandom_range(0, 1)), BASE + 32'(i * 64), 3'd6,
                 6'($urandom), 0, "fill");
      end
      for (int i = 0; i < 4; i++)
         get_req(BASE + 32'($urandom_range(0, 63) * 64), 3'd6,
                 6'($urandom), 1, "fill_get");
   endtask

   task automatic test_single_beat();
      wd[0] = rnd128();
      wm[0] = 16'hFFFF;
      put_req(3'd0, BASE + 32'h10, 3'd4, 6'h05, 0, "putfull");
      get_req(BASE + 32'h10, 3'd4, 6'h06, 0, "get_d0");
      wd[0] = {rnd128() >> 32, 32'hAABBCCDD};
      wm[0] = 16'h000F;
      put_req(3'd1, BASE + 32'h10, 3'd4, 6'h07, 0, "putpartial");
      get_req(BASE + 32'h10, 3'd4, 6'h08, 0, "get_partial");
   endtask

   task automatic test_burst();
      for (int k = 0; k < 4; k++) begin
         wd[k] = rnd128();
         wm[k] = 16'hFFFF;
      end
      put_req(3'd0, BASE + 32'h40, 3'd6, 6'h2A, 3, "burst_put");
      get_req(BASE + 32'h40, 3'd6, 6'h15, 2, "burst_get");
      for (int k = 0; k < 2; k++) begin
         wd[k] = rnd128();
         wm[k] = 16'($urandom);
      end
      put_req(3'd1, BASE + 32'h7E0, 3'd5, 6'h3F, 1, "burst2_put");
      get_req(BASE + 32'h7E0, 3'd5, 6'h01, 2, "burst2_get");
   endtask

   task automatic test_denied();
      get_req(BASE + 32'h1000, 3'd4, 6'h11, 1, "get_oob");
      for (int k = 0; k < 8; k++) begin
         wd[k] = rnd128();
         wm[k] = 16'hFFFF;
      end
      put_req(3'd2, BASE + 32'h20, 3'd4, 6'h12, 0, "arith");
      get_req(BASE + 32'h20, 3'd4, 6'h13, 0, "arith_unchanged");
      put_req(3'd0, BASE - 32'h10, 3'd4, 6'h14, 1, "put_below");
      put_req(3'd0, BASE, 3'd7, 6'h16, 0, "put_size7");
      put_req(3'd3, BASE + 32'h100, 3'd6, 6'h17, 0, "logical_burst");
      get_req(BASE, 3'd6, 6'h18, 0, "size7_unchanged");
      get_req(BASE + 32'h100, 3'd6, 6'h19, 0, "logical_unchanged");
      get_req(BASE, 3'd7, 6'h1A, 1, "get_size7");
   endtask

   task automatic test_reset_mid_burst();
      logic [148:0] zero;
      logic [7:0]   i8;
      zero = '0;
      for (int k = 0; k < 2; k++) begin
         wd[k] = rnd128();
         idle_a();
         bus.auto_in_a_valid     = 1'b1;
         bus.auto_in_a_bits_mask = 16'hFFFF;
         bus.auto_in_a_bits_data = wd[k];
         if (k == 0) begin
            bus.auto_in_a_bits_opcode  = 3'd0;
            bus.auto_in_a_bits_size    = 3'd6;
            bus.auto_in_a_bits_source  = 6'h21;
            bus.auto_in_a_bits_address = BASE + 32'h80;
         end
         @(posedge clock);
         i8 = 8'h08 + 8'(k);
         mem[i8] = wd[k];
         @(negedge clock);
      end
      idle_a();
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (got_d() !== zero || bus.auto_in_a_ready !== 1'b1) begin
         errors++;
         $display("FAIL midburst_reset: got %h ready=%b, want %h ready=1",
                  got_d(), bus.auto_in_a_ready, zero);
      end
      reset = 1'b1;
      get_req(BASE + 32'h80, 3'd6, 6'h22, 1, "midburst_get");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         wd[0] = rnd128();
         wm[0] = 16'($urandom);
         put_req(3'd1, BASE + 32'h300 + 32'(i * 16), 3'($urandom_range(0, 4)),
                 6'(i), 0, "b2b_put");
         get_req(BASE + 32'h300 + 32'(i * 16), 3'd4, 6'(i + 8), 0, "b2b_get");
      end
   endtask

   task automatic test_random();
      logic [2:0]  size;
      logic [2:0]  op;
      logic [31:0] off;
      logic [31:0] addr;
      int          r;
      for (int i = 0; i < 60; i++) begin
         size = 3'($urandom_range(0, 6));
         off  = 32'($urandom_range(0, 4095));
         off  = off & ~((32'd1 << size) - 32'd1);
         r    = int'($urandom_range(0, 9));
         addr = BASE + off;
         if (r == 0) addr = BASE + 32'h1000 + off;
         if (r == 1) addr = BASE - 32'h1000 + off;
         r = int'($urandom_range(0, 9));
         if (r < 4) begin
            get_req(addr, size, 6'($urandom), 2, "rnd_get");
         end else begin
            op = (r == 9) ? 3'(2 + $urandom_range(0, 1) * 4) :
                            3'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) begin
               wd[k] = rnd128();
               wm[k] = 16'($urandom);
            end
            put_req(op, addr, size, 6'($urandom),
                    int'($urandom_range(0, 2)), "rnd_put");
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_single_beat();
      test_burst();
      test_denied();
      test_reset_mid_burst();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tl_ram_responder.md
TL_RAM_RESPONDER -- requirements
Module: tl_ram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte base address of the 4 KiB RAM window.
REQ-002 SHALL have port clock  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port auto_in_a_valid  in  1  request beat valid.
REQ-005 SHALL have port auto_in_a_ready  out  1  request beat accepted when valid&ready ("A fire").
REQ-006 SHALL have ports auto_in_a_bits_opcode / _param / _size  in  3 each  TL opcode, ignored param, log2 byte size.
REQ-007 SHALL have ports auto_in_a_bits_source  in  6  and  auto_in_a_bits_address  in  32.
REQ-008 SHALL have ports auto_in_a_bits_mask  in  16,  auto_in_a_bits_data  in  128,  auto_in_a_bits_corrupt  in  1 (ignored).
REQ-009 SHALL have port auto_in_d_ready  in  1  response beat consumed when valid&ready ("D fire").
REQ-010 SHALL have port auto_in_d_valid  out  1  response beat valid.
REQ-011 SHALL have ports auto_in_d_bits_opcode  out 3,  _param  out 2,  _size  out 3,  _source  out 6,  _sink  out 4.
REQ-012 SHALL have ports auto_in_d_bits_denied  out 1,  _data  out 128,  _corrupt  out 1.

Function
REQ-013 SHALL hold 256 x 128-bit RAM; index = address[11:4] + beat; address[3:0] ignored.
REQ-014 SHALL support Get (4), PutFullData (0) and PutPartialData (1); all other opcodes are unsupported.
REQ-015 SHALL compute beats = 1 for size<=4, else 2^(size-4); size 5 -> 2 beats, size 6 -> 4 beats.
REQ-016 SHALL flag a request denied when address is outside [BASE_ADDR, BASE_ADDR+4096), size>6, or opcode is unsupported.
REQ-017 SHALL implement FSM states IDLE, PUT, GET, ACK; reset state IDLE.
REQ-018 SHALL drive a_ready=1 only in IDLE and PUT; a_ready=0 in GET and ACK.
REQ-019 IDLE, A fire: SHALL latch opcode, size, source, index base and denied flag, then go to GET if Get.
REQ-020 IDLE, A fire of Put or unsupported opcode: SHALL go to ACK if beats=1, else PUT with beat counter=1.
REQ-021 PUT: each A fire SHALL increment the beat counter; the fire carrying beat index beats-1 SHALL go to ACK.
REQ-022 In PUT, the opcode/size/source/address of later beats SHALL be ignored; the first-beat values SHALL be used.
REQ-023 Every A fire of a non-denied Put SHALL write data bytes whose mask bit is 1 at the current beat index, same edge.
REQ-024 Denied requests SHALL never modify RAM.
REQ-025 ACK: SHALL drive d_valid=1, opcode=0 (AccessAck), data=0, corrupt=0, denied=latched flag; D fire SHALL go to IDLE.
REQ-026 GET: SHALL drive d_valid=1, opcode=1 (AccessAckData), one beat per D fire, beat counter from 0.
REQ-027 GET data SHALL be RAM[index base + beat]; denied Get SHALL output data=0, denied=1 and corrupt=1 on every beat.
REQ-028 GET: D fire on beat beats-1 SHALL go to IDLE; otherwise the next beat SHALL be presented the following cycle.
REQ-029 All D beats SHALL carry param=0, sink=0, size=latched size and source=latched source.
REQ-030 SHALL give d_valid exactly 1 cycle after the A fire that completes a request (Get fire or last Put beat).
REQ-031 SHALL hold all D fields stable while d_valid=1 and d_ready=0.
REQ-032 Back-to-back: a new A fire SHALL be possible the cycle after the final D fire; no A/D overlap.
REQ-033 A Get following a Put to the same index SHALL return the written data.

Reset
REQ-034 While reset=0 at a clock edge: state=IDLE, beat counter=0, d_valid=0, a_ready=1 on the next cycle.
REQ-035 Reset mid-burst SHALL abandon the transaction; Put beats already accepted SHALL stay written; RAM is not cleared.
REQ-036 All D data/field outputs SHALL read 0 after reset until the first response.

Verification
REQ-037 PutFull size 4, addr BASE+0x10, mask 0xFFFF, data D0; then Get size 4 same address -> AccessAck denied=0, then AccessAckData data=D0, 1 beat.
REQ-038 PutPartial mask 0x000F data 0xAABBCCDD over D0 -> Get returns D0 with low 32 bits 0xAABBCCDD.
REQ-039 Put size 6 (4 beats) at BASE+0x40, d_ready held 0 for 3 cycles -> single AccessAck held stable; Get size 6 returns 4 beats in order, source echoed.
REQ-040 Get at BASE+0x1000 -> 1 beat with denied=1, corrupt=1, data=0; opcode 2 (Arithmetic) -> AccessAck denied=1, RAM unchanged.
REQ-041 Reset=0 after beat 2 of a 4-beat Put -> d_valid=0, a_ready=1; Get returns the new data for beats 0-1 and the old data for beats 2-3.
